// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared constants, FSM state codes and address helpers for the
// fetch sequencer and its PC register.
package pc_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef logic [2:0] state_t;

    localparam state_t ST_BOOT  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;
    localparam state_t ST_FAULT = 3'd5;

    // Clear the byte-offset bits so the address points at a whole word.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_next_reg.sv
// pc_next_reg: next-PC selection (redirect target over sequential +4) and the
// program counter register itself.
module pc_next_reg
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        step_en,
    output logic [31:0] pc
);

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;

    // Redirect always beats the sequential step; +4 wraps modulo 2^32.
    always_comb begin
        pc_next_s = pc_r;
        if (redirect_en) begin
            pc_next_s = redirect_pc;
        end else if (step_en) begin
            pc_next_s = pc_r + PC_STEP;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Program counter register, cleared asynchronously to the boot address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the fetch PC, issues one instruction-memory read at a
// time and hands each fetched word to decode through a valid/ready handshake.
// Build macro PC_FETCH_MISALIGN_TRAP_EN: a redirect with a non-word-aligned
// target traps into a sticky FAULT state; without it the target is aligned.
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    state_t      state_r;
    state_t      state_next_s;
    logic        redir_en_s;
    logic        step_en_s;
    logic        capture_s;
    logic        misalign_s;
    logic [31:0] redir_target_s;
    logic [31:0] pc_s;
    logic        req_r;
    logic        valid_r;
    logic [31:0] instr_r;
    logic [31:0] ipc_r;

    // Classify the redirect target: either trap on misalignment or align it.
    always_comb begin
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        misalign_s     = redirect_i & (redirect_pc_i[1:0] != 2'b00);
        redir_target_s = redirect_pc_i;
`else
        misalign_s     = 1'b0;
        redir_target_s = align_word(redirect_pc_i);
`endif
    end

    // Next-state and PC-control decode; only WAIT/DRAIN look at rvalid.
    always_comb begin
        state_next_s = state_r;
        redir_en_s   = 1'b0;
        step_en_s    = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_BOOT: begin
                redir_en_s   = redirect_i;
                state_next_s = ST_REQ;
            end
            ST_REQ: begin
                redir_en_s = redirect_i;
                if (imem_gnt_i) begin
                    // A redirect racing the grant leaves a stale response to drop.
                    state_next_s = redirect_i ? ST_DRAIN : ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                redir_en_s = redirect_i;
                if (imem_rvalid_i) begin
                    if (redirect_i) begin
                        state_next_s = ST_REQ;
                    end else begin
                        capture_s    = 1'b1;
                        step_en_s    = 1'b1;
                        state_next_s = ST_HOLD;
                    end
                end else if (redirect_i) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                redir_en_s = redirect_i;
                if (redirect_i || if_ready_i) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                redir_en_s = redirect_i;
                if (imem_rvalid_i) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            ST_FAULT: begin
                state_next_s = ST_FAULT;
            end
`endif
            default: begin
                state_next_s = ST_BOOT;
            end
        endcase
        // A misaligned redirect overrides everything and freezes the PC.
        if (misalign_s && (state_r != ST_FAULT)) begin
            state_next_s = ST_FAULT;
            redir_en_s   = 1'b0;
            step_en_s    = 1'b0;
            capture_s    = 1'b0;
        end else begin
            state_next_s = state_next_s;
        end
    end

    pc_next_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_next_reg (
        .clk        (clk_i),
        .rst        (rst_i),
        .redirect_en(redir_en_s),
        .redirect_pc(redir_target_s),
        .step_en    (step_en_s),
        .pc         (pc_s)
    );

    // FSM state plus registered request/valid flags and the held instruction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_BOOT;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            instr_r <= NOP_INSTR;
            ipc_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            req_r   <= (state_next_s == ST_REQ);
            valid_r <= (state_next_s == ST_HOLD);
            if (capture_s) begin
                instr_r <= imem_rdata_i;
                ipc_r   <= pc_s;
            end else begin
                instr_r <= instr_r;
                ipc_r   <= ipc_r;
            end
        end
    end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic fault_r;

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= (state_next_s == ST_FAULT);
        end
    end

    assign fault_o = fault_r;
`else
    assign fault_o = 1'b0;
`endif

    assign imem_req_o  = req_r;
    assign imem_addr_o = pc_s;
    assign pc_o        = pc_s;
    assign if_valid_o  = valid_r;
    assign if_instr_o  = instr_r;
    assign if_pc_o     = ipc_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed scenarios plus a randomized run checked
// against a transaction-level reference model of the fetch sequencer.
module tb_pc_fetch_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        if_valid_o;
    logic        if_ready_i = 1'b0;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] pc_o;
    logic        fault_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    pc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
        .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
        .pc_o(pc_o), .fault_o(fault_o)
    );

    // Reference model: what has been fetched, what is in flight, what decode sees.
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_booted, m_out, m_keep, m_valid, m_fault;
    int          pend_cnt;
    logic [31:0] pend_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_2468;
    endfunction

    function automatic bit m_req();
        return m_booted && !m_fault && !m_out && !m_valid;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0000_0013; m_ipc = 32'h0;
        m_booted = 0; m_out = 0; m_keep = 0; m_valid = 0; m_fault = 0;
        pend_cnt = 0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit          bad;
        if (m_fault) return;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        tgt = redirect_pc_i;
        bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
        tgt = redirect_pc_i & 32'hFFFF_FFFC;
        bad = 0;
`endif
        if (bad) begin
            m_fault = 1; m_valid = 0;
            return;
        end
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_valid) begin
            if (if_ready_i || redirect_i) m_valid = 0;
        end else if (m_out) begin
            if (imem_rvalid_i) begin
                m_out = 0;
                if (m_keep && !redirect_i) begin
                    m_valid = 1; m_instr = imem_rdata_i; m_ipc = m_pc; m_pc = m_pc + 32'd4;
                end
            end else if (redirect_i) begin
                m_keep = 0;
            end
        end else if (imem_gnt_i) begin
            m_out = 1; m_keep = !redirect_i;
        end
        if (redirect_i) m_pc = tgt;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; if_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        #3;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_i = 1'b1;
        #1;
        if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req_o); end
        n_cmp++;
        if (pc_o !== 32'h0 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h/%h want 0", pc_o, imem_addr_o); end
        n_cmp++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", if_valid_o); end
        n_cmp++;
        if (if_instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr got %h want 00000013", if_instr_o); end
        n_cmp++;
        if (if_pc_o !== 32'h0 || fault_o !== 1'b0) begin n_fail++; $display("FAIL rst_ifpc_fault got %h/%b want 0/0", if_pc_o, fault_o); end
        n_cmp++;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();
        tick();
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL first_req got %b@%h want 1@0", imem_req_o, imem_addr_o);
        end
        n_cmp++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] ea;
        do_reset();
        if_ready_i = 1'b1;
        tick();
        for (int c = 1; c <= 9; c++) begin
            if (imem_req_o !== (c % 3 == 1)) begin n_fail++; $display("FAIL zw_req c%0d got %b", c, imem_req_o); end
            n_cmp++;
            if (c % 3 == 1) begin
                ea = 32'(4 * ((c - 1) / 3));
                if (imem_addr_o !== ea) begin n_fail++; $display("FAIL zw_addr c%0d got %h want %h", c, imem_addr_o, ea); end
                n_cmp++;
            end
            if (if_valid_o !== (c % 3 == 0)) begin n_fail++; $display("FAIL zw_valid c%0d got %b", c, if_valid_o); end
            n_cmp++;
            if (c % 3 == 0) begin
                ea = 32'(4 * (c / 3 - 1));
                if (if_pc_o !== ea || if_instr_o !== mem_word(ea)) begin
                    n_fail++; $display("FAIL zw_out c%0d got %h:%h want %h:%h", c, if_pc_o, if_instr_o, ea, mem_word(ea));
                end
                n_cmp++;
            end
            imem_gnt_i    = (c % 3 == 1);
            imem_rvalid_i = (c % 3 == 2);
            imem_rdata_i  = mem_word(32'(4 * ((c - 2) / 3)));
            tick();
        end
    endtask

    task automatic test_grant_delay();
        do_reset();
        if_ready_i = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL gd_stable c%0d got req%b addr%h v%b", c, imem_req_o, imem_addr_o, if_valid_o);
            end
            n_cmp++;
            imem_gnt_i = (c == 5);
            tick();
        end
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h0);
        tick();
        if (if_valid_o !== 1'b1 || if_instr_o !== mem_word(32'h0)) begin
            n_fail++; $display("FAIL gd_data got v%b %h want v1 %h", if_valid_o, if_instr_o, mem_word(32'h0));
        end
        n_cmp++;
        imem_rvalid_i = 1'b0;
        tick();
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
            n_fail++; $display("FAIL gd_next got %b@%h want 1@4", imem_req_o, imem_addr_o);
        end
        n_cmp++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        tick();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        if (pc_o !== 32'h100 || imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL rw_redir got pc%h req%b want pc100 req0", pc_o, imem_req_o);
        end
        n_cmp++;
        redirect_i = 1'b0;
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || if_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rw_req got %b@%h v%b want 1@100 v0", imem_req_o, imem_addr_o, if_valid_o);
        end
        n_cmp++;
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h100);
        tick();
        if (if_instr_o === 32'hDEAD_BEEF || if_instr_o !== mem_word(32'h100) || if_pc_o !== 32'h100) begin
            n_fail++; $display("FAIL rw_data got %h@%h want %h@100", if_instr_o, if_pc_o, mem_word(32'h100));
        end
        n_cmp++;
        imem_rvalid_i = 1'b0;
    endtask

    task automatic test_hold_stall();
        do_reset();
        tick();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h0);
        tick();
        imem_rvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (if_valid_o !== 1'b1 || if_instr_o !== mem_word(32'h0) || pc_o !== if_pc_o + 32'd4 || pc_o !== 32'h4) begin
                n_fail++; $display("FAIL hs_stable i%0d got v%b %h pc%h ifpc%h", i, if_valid_o, if_instr_o, pc_o, if_pc_o);
            end
            n_cmp++;
            tick();
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            n_fail++; $display("FAIL hs_redir got v%b %b@%h want v0 1@40", if_valid_o, imem_req_o, imem_addr_o);
        end
        n_cmp++;
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wr_top got %b@%h want 1@fffffffc", imem_req_o, imem_addr_o);
        end
        n_cmp++;
        redirect_i = 1'b0; imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'hFFFF_FFFC);
        tick();
        imem_rvalid_i = 1'b0; if_ready_i = 1'b1;
        if (if_pc_o !== 32'hFFFF_FFFC || pc_o !== 32'h0) begin
            n_fail++; $display("FAIL wr_pc got ifpc%h pc%h want fffffffc/0", if_pc_o, pc_o);
        end
        n_cmp++;
        tick();
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL wr_next got %b@%h want 1@0", imem_req_o, imem_addr_o);
        end
        n_cmp++;
    endtask

    task automatic test_misalign();
        do_reset();
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h102;
        tick();
        redirect_i = 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            if (fault_o !== 1'b1 || imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL ma_fault i%0d got f%b req%b v%b", i, fault_o, imem_req_o, if_valid_o);
            end
            n_cmp++;
            imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; if_ready_i = 1'b1;
            redirect_i = (i == 1); redirect_pc_i = 32'h200;
            tick();
        end
        do_reset();
        if (fault_o !== 1'b0) begin n_fail++; $display("FAIL ma_clear got %b want 0", fault_o); end
        n_cmp++;
`else
        if (fault_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
            n_fail++; $display("FAIL ma_align got f%b %b@%h want f0 1@100", fault_o, imem_req_o, imem_addr_o);
        end
        n_cmp++;
`endif
    endtask

    task automatic test_reset_midflight();
        do_reset();
        tick();
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h0);
        tick();
        imem_rvalid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        if (if_valid_o !== 1'b0 || pc_o !== 32'h0 || if_instr_o !== 32'h0000_0013) begin
            n_fail++; $display("FAIL mf_async got v%b pc%h %h", if_valid_o, pc_o, if_instr_o);
        end
        n_cmp++;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
                n_fail++; $display("FAIL mf_stale i%0d got v%b %b@%h", i, if_valid_o, imem_req_o, imem_addr_o);
            end
            n_cmp++;
        end
        imem_rvalid_i = 1'b0;
    endtask

    task automatic drive_random();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin imem_rvalid_i = 1'b1; imem_rdata_i = pend_data; end
        end else if (!m_out && $urandom_range(0, 9) == 0) begin
            imem_rvalid_i = 1'b1;
        end
        if (m_req() && $urandom_range(0, 3) != 0) begin
            imem_gnt_i = 1'b1; pend_cnt = $urandom_range(1, 3); pend_data = mem_word(m_pc);
        end
        redirect_i = ($urandom_range(0, 7) == 0);
        redirect_pc_i = $urandom;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        redirect_pc_i = redirect_pc_i & 32'hFFFF_FFFC;
`endif
        if_ready_i = ($urandom_range(0, 1) == 1);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            drive_random();
            tick();
            if (imem_req_o !== m_req()) begin n_fail++; $display("FAIL rnd_req k%0d got %b want %b", k, imem_req_o, m_req()); end
            n_cmp++;
            if (imem_addr_o !== m_pc || pc_o !== m_pc) begin n_fail++; $display("FAIL rnd_pc k%0d got %h/%h want %h", k, imem_addr_o, pc_o, m_pc); end
            n_cmp++;
            if (if_valid_o !== m_valid) begin n_fail++; $display("FAIL rnd_valid k%0d got %b want %b", k, if_valid_o, m_valid); end
            n_cmp++;
            if (if_instr_o !== m_instr || if_pc_o !== m_ipc) begin
                n_fail++; $display("FAIL rnd_out k%0d got %h@%h want %h@%h", k, if_instr_o, if_pc_o, m_instr, m_ipc);
            end
            n_cmp++;
            if (fault_o !== m_fault) begin n_fail++; $display("FAIL rnd_fault k%0d got %b want %b", k, fault_o, m_fault); end
            n_cmp++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_zero_wait();
        test_grant_delay();
        test_redirect_wait();
        test_hold_stall();
        test_wrap();
        test_misalign();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-stage controller that owns the program counter and sequences single-outstanding instruction-memory reads. It selects the next PC (sequential +4 or branch redirect from the BRU), drives the request/grant/response handshake to instruction memory, and presents each fetched instruction to decode with a valid/ready handshake. It sits between the BRU/hazard logic and the IF/ID boundary.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset and first fetch address
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- redirect_i  in  1  branch/jump taken (br_sel from BRU)
- redirect_pc_i  in  32  redirect target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, equals pc_o
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  read data valid, at earliest 1 cycle after grant
- imem_rdata_i  in  32  instruction word
- if_valid_o  out  1  instruction available to decode
- if_ready_i  in  1  decode accepts
- if_instr_o  out  32  instruction
- if_pc_o  out  32  PC of if_instr_o
- pc_o  out  32  current fetch PC
- fault_o  out  1  misaligned-redirect fault (macro-dependent)

## Operation
- States: BOOT, REQ, WAIT, HOLD, DRAIN, FAULT (FAULT only with macro).
- BOOT: one cycle after reset release -> REQ.
- REQ: imem_req_o=1, address = pc_o, stable until grant. gnt -> WAIT. redirect without gnt: pc<=target, stay REQ. redirect with gnt: pc<=target, -> DRAIN.
- WAIT: rvalid (no redirect): if_instr<=rdata, if_pc<=pc, pc<=pc+4, if_valid<=1, -> HOLD. redirect without rvalid: pc<=target, -> DRAIN. redirect with rvalid: data discarded, pc<=target, -> REQ.
- HOLD: if_valid_o=1, outputs stable. if_ready_i (no redirect): if_valid<=0, -> REQ. redirect (regardless of if_ready_i): if_valid<=0, pc<=target, -> REQ; decode is flushed by its own control.
- DRAIN: wait rvalid, discard it, -> REQ. Further redirect in DRAIN: pc<=target, stay DRAIN.
- Redirect always has priority over sequential increment.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- At most one outstanding imem transaction; rvalid outside WAIT/DRAIN ignored.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=pc_o=RESET_PC, if_valid_o=0, if_instr_o=32'h0000_0013 (NOP), if_pc_o=0, fault_o=0, state=BOOT.
- First request asserted cycle 1 after reset release.
- Zero-wait memory (gnt in REQ, rvalid next cycle): REQ, WAIT, HOLD -> one instruction per 3 cycles with if_ready_i held high.
- Redirect visible on pc_o/imem_addr_o the cycle after redirect_i.
- Reset mid-transaction: all state cleared asynchronously; in-flight response after reset ignored (BOOT/REQ do not sample rvalid).

## Configuration
- PC_FETCH_MISALIGN_TRAP_EN defined: redirect_pc_i[1:0]!=0 -> pc not updated, -> FAULT; fault_o=1, imem_req_o=0, if_valid_o=0; exit only by reset.
- Undefined: redirect target low two bits forced to 0, no FAULT state, fault_o tied 0.

## Structure
- Package pc_fetch_pkg: state enum, NOP_INSTR constant (32'h0000_0013), PC_STEP (32'd4).
- Sub-module pc_next_reg: next-PC mux (redirect vs pc+4, enable) plus PC register with async active-high reset to RESET_PC; FSM stays in top.

## Test plan
- Reset release, zero-wait memory, if_ready_i=1 -> addresses 0x0,0x4,0x8 each 3 cycles apart; if_pc_o matches.
- Grant delayed 4 cycles in REQ -> imem_addr_o stable 0x0 for all 5 cycles, no spurious if_valid_o.
- Redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> data dropped, next request at 0x100, if_instr_o never 0xDEADBEEF.
- HOLD with if_ready_i=0 for 5 cycles -> if_valid_o/if_instr_o stable, pc_o=if_pc_o+4; then redirect to 0x40 -> if_valid_o low next cycle, request at 0x40.
- Redirect to 0xFFFF_FFFC, sequential fetch -> next address 0x0000_0000.
- Redirect to 0x102: with macro fault_o=1, imem_req_o=0 until reset; without macro next request at 0x100.
